// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial add/subtract controller.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_e;

endpackage

// File: rtl/serial_adder_ctrl_fac.sv
// One-bit full-adder cell; the only adder logic in the serial datapath.
module fac (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic z,
    output logic carry_out
);

    assign z         = x ^ y ^ ci;
    assign carry_out = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract unit: one fac cell sequenced LSB-first over WIDTH bits
// behind a start/busy/done handshake.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry_out;
    logic             r_overflow;

    logic w_accept;
    logic w_run;
    logic w_last;
    logic w_z;
    logic w_co;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_run    = (r_state == ST_RUN);
    assign w_last   = w_run && (r_cnt == LAST_BIT);

    fac u_fac (
        .x         (r_op_a[0]),
        .y         (r_op_b[0]),
        .ci        (r_carry),
        .z         (w_z),
        .carry_out (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_state_d = ST_RUN;
            ST_RUN:  if (r_cnt == LAST_BIT) w_state_d = ST_DONE;
            ST_DONE: w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            // Subtract as a + ~b + 1: invert b here, inject the +1 as the initial carry.
            r_op_a  <= a;
            r_op_b  <= b ^ {WIDTH{sub}};
            r_carry <= sub;
            r_cnt   <= '0;
            r_sum   <= '0;
        end else if (w_run) begin
            r_sum   <= {w_z, r_sum[WIDTH-1:1]};
            r_op_a  <= {1'b0, r_op_a[WIDTH-1:1]};
            r_op_b  <= {1'b0, r_op_b[WIDTH-1:1]};
            r_carry <= w_co;
            if (w_last) begin
                r_carry_out <= w_co;
                r_overflow  <= r_carry ^ w_co;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign sum       = r_sum;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry_out;
    logic       overflow;

    int n_total;
    int n_bad;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_sum"}, 32'(sum), 32'd0);
        check_eq({tag, "_co"}, 32'(carry_out), 32'd0);
        check_eq({tag, "_ov"}, 32'(overflow), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic isub, input logic [7:0] esum, input logic eco,
                          input logic eov);
        int n;
        a     = ia;
        b     = ib;
        sub   = isub;
        start = 1'b1;
        tick();
        // Scramble inputs after acceptance; the result must not change.
        start = 1'b0;
        a     = ~ia;
        b     = ~ib;
        sub   = ~isub;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check_eq({tag, "_busy_cycles"}, 32'(n), 32'd8);
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check_eq({tag, "_sum"}, 32'(sum), 32'(esum));
        check_eq({tag, "_co"}, 32'(carry_out), 32'(eco));
        check_eq({tag, "_ov"}, 32'(overflow), 32'(eov));
        tick();
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_sum_hold"}, 32'(sum), 32'(esum));
    endtask

    logic [7:0] hs_exp [3];

    initial begin
        int n;
        n_total   = 0;
        n_bad     = 0;
        hs_exp[0] = 8'h08;
        hs_exp[1] = 8'hD0;
        hs_exp[2] = 8'h98;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_idle_zero("reset");

        run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // start held high with fresh operands every cycle: accepts at edges 0, 10, 20.
        sub = 1'b0;
        for (int i = 0; i < 30; i++) begin
            a     = 8'(i * 7 + 3);
            b     = 8'(i * 13 + 5);
            start = 1'b1;
            tick();
            check_eq($sformatf("hs_busy_%0d", i), 32'(busy), 32'((i % 10) < 8));
            check_eq($sformatf("hs_done_%0d", i), 32'(done), 32'((i % 10) == 8));
            if ((i % 10) >= 8) begin
                check_eq($sformatf("hs_sum_%0d", i), 32'(sum), 32'(hs_exp[i / 10]));
            end
            if (i == 10 || i == 20) begin
                check_eq($sformatf("hs_sum_clr_%0d", i), 32'(sum), 32'd0);
            end
        end
        start = 1'b0;
        tick();
        check_eq("hs_idle", 32'(busy), 32'd0);

        // Leave carry_out/overflow at 1 so the abort visibly clears them.
        run_op("pre_abort", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        a     = 8'h5A;
        b     = 8'h33;
        sub   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check_eq("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_zero("abort");
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) n++;
            tick();
        end
        check_eq("abort_no_done", 32'(n), 32'd0);
        run_op("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add/subtract controller that time-multiplexes one instance of the team's one-bit full-adder cell `fac` over a WIDTH-bit operand pair. It holds shift registers for the operands and result plus a carry flip-flop, and sequences one bit per clock from LSB to MSB. A start/busy/done handshake presents it to the surrounding lab datapath as a multi-cycle arithmetic unit.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; **one clock; reset is synchronous and active-high**.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a−b; latched with the operands.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; holds until the next accepted start.
- carry_out  output  1  final carry; for subtract, 1 = no borrow.
- overflow  output  1  two's-complement overflow of the result.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE: if start=1, latch a into op_a, latch b^{WIDTH{sub}} into op_b, set carry to sub, set bit counter to 0, clear sum, and go to RUN. The previous sum, carry_out and overflow stay visible until this edge.
- RUN: each cycle `fac` computes on op_a[0], op_b[0] and carry.
  - At the clock edge, sum shifts right and takes fac.z into its MSB.
  - op_a and op_b shift right, with 0 shifted in.
  - carry takes fac.carry_out, and the counter increments.
  - When the counter equals WIDTH−1, the edge also loads carry_out with fac.carry_out and overflow with carry^fac.carry_out, then moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start is ignored in RUN and DONE. It is not queued.
- A change on a, b or sub after acceptance has no effect.
- Arithmetic is modulo 2^WIDTH. The counter is $clog2(WIDTH) bits wide and never wraps within an operation.
- Reset values: state IDLE, busy 0, done 0, sum 0, carry_out 0, overflow 0, counter 0, carry 0.
- rst has priority over start in the same cycle.
- rst during RUN or DONE aborts the operation. Outputs return to their reset values and no done pulse is produced.

## Timing
- Start accepted at edge k: busy=1 during cycles k+1 .. k+WIDTH.
- DONE is entered at edge k+WIDTH; done=1 and busy=0 in cycle k+WIDTH+1.
- sum, carry_out and overflow are final once done is high.
- The earliest next accept is at edge k+WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- busy and done are registered state decodes, never high together.
- There is no combinational path from inputs to outputs.

## Structure
- Shared package/include `serial_adder_pkg`:
  - state encoding localparams (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2);
  - default WIDTH constant.
- One sub-module, `fac`, instantiated once as the bit-slice datapath. No other adder logic is permitted.
- Registers: state, counter, carry, op_a, op_b and sum shift registers, carry_out, overflow.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, sub=0 → done in cycle k+9: sum=0x8D, carry_out=0, overflow=1.
- a=0xFF, b=0x01, sub=0 → sum=0x00, carry_out=1, overflow=0.
- a=0x10, b=0x20, sub=1 → sum=0xF0, carry_out=0 (borrow), overflow=0.
- a=0x80, b=0x01, sub=1 → sum=0x7F, carry_out=1, overflow=1.
- Handshake check:
  - hold start=1 continuously with new a/b each cycle;
  - accepts occur exactly every 10 cycles and use the operands present at each accept edge;
  - busy is high for exactly 8 cycles and done for 1 cycle;
  - sum keeps the prior result until the next accept.
- Reset mid-operation:
  - assert rst for 1 cycle at RUN cycle 4;
  - all outputs read 0 the next cycle and no done pulse appears;
  - a fresh 0x01+0x01 completes with sum=0x02.
